// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg : shared types and sizing helpers for multi_debouncer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package debounce_pkg;

  typedef enum logic [0:0] {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } ch_state_e;

  function automatic int tick_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel : synchroniser, stability FSM and db/edge registers for one
// input. Edge pulses exist only with DEBOUNCE_EDGE_PULSE_EN defined. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

  logic          meta;
  logic          sync;
  ch_state_e     state;
  ch_state_e     state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          db_nx;
  logic          advance;
  logic          mismatch;

  assign mismatch = sync ^ db;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      state <= STABLE;
      cnt   <= '0;
      db    <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      state <= state_nx;
      cnt   <= cnt_nx;
      db    <= db_nx;
    end
  end

  // The tick that reveals a mismatch already counts, so latency stays within
  // (STABLE_TICKS-1) and STABLE_TICKS tick periods plus synchroniser delay.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    db_nx    = db;
    advance  = 1'b0;
    unique case (state)
      STABLE: begin
        if (mismatch) begin
          state_nx = PENDING;
          advance  = tick;
        end
      end
      PENDING: begin
        if (!mismatch) begin
          state_nx = STABLE;
          cnt_nx   = '0;
        end else begin
          advance = tick;
        end
      end
      default: state_nx = STABLE;
    endcase
    if (advance) begin
      if (cnt == LAST) begin
        db_nx    = ~db;
        cnt_nx   = '0;
        state_nx = STABLE;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= db_nx & ~db;
      fall_q <= ~db_nx & db;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ---------------------------------------------------------------------------
// multi_debouncer : CHANNELS-wide debouncer with a shared sample prescaler.
// Edge pulses require DEBOUNCE_EDGE_PULSE_EN; otherwise rise/fall tie to 0. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int CHANNELS     = 5,
  parameter int CLK_HZ       = 100_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int STABLE_TICKS = 20
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] db,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
);

  localparam int TICK_DIV = tick_div(CLK_HZ, TICK_HZ);
  localparam int PW       = cnt_width(TICK_DIV);

  logic tick;

  generate
    if (TICK_DIV <= 1) begin : g_tick_always
      assign tick = 1'b1;
    end else begin : g_prescaler
      localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pre;

      always_ff @(posedge clock) begin
        if (reset)     pre <= '0;
        else if (tick) pre <= '0;
        else           pre <= pre + 1'b1;
      end

      assign tick = (pre == PRE_LAST);
    end
  endgenerate

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_ch (
        .clock(clock),
        .reset(reset),
        .tick (tick),
        .raw  (in[i]),
        .db   (db[i]),
        .rise (rise[i]),
        .fall (fall[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire
